// File: rtl/lcd_bus_responder_pkg.sv
// Shared definitions for the LCD bus responder: FSM state encoding, command
// decode, DDRAM geometry and the blank fill character.
package lcd_bus_responder_pkg;

    localparam int unsigned DdramDepth = 32;
    localparam int unsigned AddrW      = 5;
    localparam logic [7:0]  BlankChar  = 8'h20;

    // Bit positions of the option fields inside instruction bytes.
    localparam int unsigned EntryIdBit  = 1;
    localparam int unsigned DisplayDBit = 2;
    localparam int unsigned FuncDlBit   = 4;

    typedef enum logic [1:0] {
        StOff,
        StInit,
        StIdle,
        StBusy
    } state_e;

    typedef enum logic [3:0] {
        CmdNop,
        CmdClear,
        CmdHome,
        CmdEntry,
        CmdDisplay,
        CmdShift,
        CmdFuncSet,
        CmdCgram,
        CmdSetAddr
    } cmd_e;

    // The instruction class is selected by the most significant set bit.
    function automatic cmd_e decode_cmd(input logic [7:0] b);
        casez (b)
            8'b1???????: return CmdSetAddr;
            8'b01??????: return CmdCgram;
            8'b001?????: return CmdFuncSet;
            8'b0001????: return CmdShift;
            8'b00001???: return CmdDisplay;
            8'b000001??: return CmdEntry;
            8'b0000001?: return CmdHome;
            8'b00000001: return CmdClear;
            default:     return CmdNop;
        endcase
    endfunction

endpackage

// File: rtl/lcd_enable_sync.sv
// Two-flop synchronizer for the asynchronous enable strobe plus edge detect.
//   clk_i/rst_i : clock, async active-high reset
//   clr_i       : synchronous clear (panel powered down)
//   en_async_i  : raw enable strobe
//   en_sync_o   : synchronized enable
//   rise_o      : one-cycle pulse on synchronized rising edge
//   fall_o      : one-cycle pulse on synchronized falling edge
module lcd_enable_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_async_i,
    output logic en_sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else if (clr_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= en_async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign en_sync_o = sync_q;
    assign rise_o    = sync_q & ~prev_q;
    assign fall_o    = ~sync_q & prev_q;

endmodule

// File: rtl/lcd_bus_responder.sv
// Behavioural responder for an HD44780-style character LCD bus (32-byte DDRAM).
//   clk, reset               : clock, async active-high reset
//   lcdOn                    : panel power, low forces everything back to reset state
//   lcdBusIn/lcdRsSelect/
//   lcdReadWriteSel/lcdEnable: controller-side bus, enable is asynchronous
//   lcdBusOut/lcdBusDriveEn  : read data and its drive enable
//   busyFlag, addrCounter,
//   displayOn, cmdError      : internal status
//   dbgAddr/dbgData          : combinational DDRAM peek
module lcd_bus_responder
    import lcd_bus_responder_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES      = 40,
    parameter int unsigned LONG_BUSY_CYCLES = 160
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lcdOn,
    input  logic [7:0]       lcdBusIn,
    input  logic             lcdReadWriteSel,
    input  logic             lcdRsSelect,
    input  logic             lcdEnable,
    output logic [7:0]       lcdBusOut,
    output logic             lcdBusDriveEn,
    output logic             busyFlag,
    output logic [AddrW-1:0] addrCounter,
    output logic             displayOn,
    input  logic [AddrW-1:0] dbgAddr,
    output logic [7:0]       dbgData,
    output logic             cmdError
);

    // Counters count down to zero, so a load of N-1 gives N busy cycles.
    localparam logic [15:0] BusyLoad = 16'(BUSY_CYCLES - 1);
    localparam logic [15:0] LongLoad = 16'(LONG_BUSY_CYCLES - 1);

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [AddrW-1:0] ac_q, ac_d, ac_step;
    logic             id_q, id_d;
    logic             disp_q, disp_d;
    logic             err_q, err_d;
    logic             rs_q, rw_q;
    logic [7:0]       bus_q;
    logic             active_q, commit_q;
    logic             en_sync, en_rise, en_fall;
    logic             busy;
    logic             ddram_we, ddram_clr;
    logic [7:0]       ddram_q [DdramDepth];

    lcd_enable_sync u_sync (
        .clk_i      (clk),
        .rst_i      (reset),
        .clr_i      (~lcdOn),
        .en_async_i (lcdEnable),
        .en_sync_o  (en_sync),
        .rise_o     (en_rise),
        .fall_o     (en_fall)
    );

    // Bus capture and commit pipeline; a commit needs a seen rising edge first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            bus_q    <= 8'h00;
            active_q <= 1'b0;
            commit_q <= 1'b0;
        end else if (!lcdOn) begin
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            bus_q    <= 8'h00;
            active_q <= 1'b0;
            commit_q <= 1'b0;
        end else begin
            if (en_sync) begin
                rs_q  <= lcdRsSelect;
                rw_q  <= lcdReadWriteSel;
                bus_q <= lcdBusIn;
            end
            if (en_rise) begin
                active_q <= 1'b1;
            end else if (en_fall) begin
                active_q <= 1'b0;
            end
            commit_q <= en_fall & active_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StOff;
            cnt_q   <= '0;
            ac_q    <= '0;
            id_q    <= 1'b1;
            disp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ac_q    <= ac_d;
            id_q    <= id_d;
            disp_q  <= disp_d;
            err_q   <= err_d;
        end
    end

    assign busy    = (state_q == StInit) || (state_q == StBusy);
    assign ac_step = id_q ? ac_q + 5'd1 : ac_q - 5'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ac_d      = ac_q;
        id_d      = id_q;
        disp_d    = disp_q;
        err_d     = err_q;
        ddram_we  = 1'b0;
        ddram_clr = 1'b0;

        unique case (state_q)
            StOff: begin
                if (lcdOn) begin
                    state_d = StInit;
                    cnt_d   = LongLoad;
                end
            end
            StInit, StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StIdle: ;
            default: state_d = StOff;
        endcase

        if (commit_q && state_q != StOff) begin
            if (rw_q) begin
                // Status reads are side-effect free; data reads advance AC.
                if (rs_q) begin
                    ac_d = ac_step;
                    if (busy) err_d = 1'b1;
                end
            end else if (busy) begin
                // Dropped write: the running busy countdown is left alone.
                err_d = 1'b1;
            end else begin
                state_d = StBusy;
                cnt_d   = BusyLoad;
                if (rs_q) begin
                    ddram_we = 1'b1;
                    ac_d     = ac_step;
                end else begin
                    unique case (decode_cmd(bus_q))
                        CmdClear: begin
                            ddram_clr = 1'b1;
                            ac_d      = '0;
                            id_d      = 1'b1;
                            cnt_d     = LongLoad;
                        end
                        CmdHome: begin
                            ac_d  = '0;
                            cnt_d = LongLoad;
                        end
                        CmdEntry:   id_d   = bus_q[EntryIdBit];
                        CmdDisplay: disp_d = bus_q[DisplayDBit];
                        // Only 8-bit mode exists, so DL is checked but not kept.
                        CmdFuncSet: if (!bus_q[FuncDlBit]) err_d = 1'b1;
                        CmdSetAddr: begin
                            ac_d = bus_q[AddrW-1:0];
                            if (bus_q[6:5] != 2'b00) err_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end

        if (!lcdOn) begin
            state_d   = StOff;
            cnt_d     = '0;
            ac_d      = '0;
            id_d      = 1'b1;
            disp_d    = 1'b0;
            err_d     = 1'b0;
            ddram_we  = 1'b0;
            ddram_clr = 1'b0;
        end
    end

    // DDRAM has no reset; the clear command is what defines its contents.
    always_ff @(posedge clk) begin
        if (ddram_clr) begin
            for (int i = 0; i < DdramDepth; i++) begin
                ddram_q[i] <= BlankChar;
            end
        end else if (ddram_we) begin
            ddram_q[ac_q] <= bus_q;
        end
    end

    assign lcdBusDriveEn = en_sync & lcdReadWriteSel & (state_q != StOff);
    assign lcdBusOut     = !lcdBusDriveEn ? 8'h00 :
                           lcdRsSelect    ? ddram_q[ac_q] : {busy, 2'b00, ac_q};
    assign busyFlag      = busy;
    assign addrCounter   = ac_q;
    assign displayOn     = disp_q;
    assign cmdError      = err_q;
    assign dbgData       = ddram_q[dbgAddr];

endmodule

// File: tb/tb_lcd_bus_responder.sv
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcdOn;
    logic [7:0] lcdBusIn;
    logic       lcdReadWriteSel;
    logic       lcdRsSelect;
    logic       lcdEnable;
    logic [7:0] lcdBusOut;
    logic       lcdBusDriveEn;
    logic       busyFlag;
    logic [4:0] addrCounter;
    logic       displayOn;
    logic [4:0] dbgAddr;
    logic [7:0] dbgData;
    logic       cmdError;

    int ncmp  = 0;
    int nfail = 0;
    int busy_hi = 0;

    lcd_bus_responder #(
        .BUSY_CYCLES      (40),
        .LONG_BUSY_CYCLES (160)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .lcdOn           (lcdOn),
        .lcdBusIn        (lcdBusIn),
        .lcdReadWriteSel (lcdReadWriteSel),
        .lcdRsSelect     (lcdRsSelect),
        .lcdEnable       (lcdEnable),
        .lcdBusOut       (lcdBusOut),
        .lcdBusDriveEn   (lcdBusDriveEn),
        .busyFlag        (busyFlag),
        .addrCounter     (addrCounter),
        .displayOn       (displayOn),
        .dbgAddr         (dbgAddr),
        .dbgData         (dbgData),
        .cmdError        (cmdError)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busyFlag) busy_hi = busy_hi + 1;

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] data;
        logic [7:0] rd;
        logic [4:0] ac;
        logic       disp;
        logic       err;
        int         busy;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state.
    logic [7:0] mdl [32];
    logic [4:0] m_ac;
    logic       m_id, m_disp, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic txn(input logic rs, input logic rw, input logic [7:0] d,
                       output logic [7:0] rd, output logic den);
        lcdRsSelect     = rs;
        lcdReadWriteSel = rw;
        lcdBusIn        = d;
        lcdEnable       = 1'b1;
        repeat (4) @(negedge clk);
        rd = lcdBusOut;
        den = lcdBusDriveEn;
        lcdEnable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) @(negedge clk);
        while (busyFlag && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busyFlag) begin
            ncmp++;
            nfail++;
            $display("FAIL wait_idle: busyFlag still 1 after 400 cycles, required 0");
        end
    endtask

    // Model of a committed write while idle; returns the expected busy length.
    function automatic int model_write(input logic rs, input logic [7:0] b);
        if (rs) begin
            mdl[m_ac] = b;
            m_ac = m_id ? m_ac + 5'd1 : m_ac - 5'd1;
            return 40;
        end
        if (b >= 8'h80) begin
            m_ac = b[4:0];
            if (b[6:0] > 7'd31) m_err = 1'b1;
        end else if (b >= 8'h40) begin
        end else if (b >= 8'h20) begin
            if (!b[4]) m_err = 1'b1;
        end else if (b >= 8'h10) begin
        end else if (b >= 8'h08) begin
            m_disp = b[2];
        end else if (b >= 8'h04) begin
            m_id = b[1];
        end else if (b == 8'h02) begin
            m_ac = 5'd0;
            return 160;
        end else if (b == 8'h01) begin
            for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
            m_ac = 5'd0;
            m_id = 1'b1;
            return 160;
        end
        return 40;
    endfunction

    initial begin
        logic [7:0]  rd;
        logic        den;
        logic [7:0]  exp_mem [32];
        logic [31:0] r;
        logic [7:0]  d, exp_rd;
        logic        rs, rw;
        int          k, exp_busy;

        reset = 1'b1;
        lcdOn = 1'b1;
        lcdBusIn = 8'h00;
        lcdReadWriteSel = 1'b0;
        lcdRsSelect = 1'b0;
        lcdEnable = 1'b0;
        dbgAddr = 5'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", busyFlag, 0);
        check("rst_ac", addrCounter, 0);
        check("rst_disp", displayOn, 0);
        check("rst_err", cmdError, 0);
        check("rst_drive", lcdBusDriveEn, 0);
        check("rst_out", lcdBusOut, 0);

        // Power-up init.
        reset = 1'b0;
        busy_hi = 0;
        wait_idle();
        check("init_busy_len", busy_hi, 160);
        txn(1'b0, 1'b1, 8'h00, rd, den);
        check("init_status", rd, 8'h00);

        // Directed table.
        tbl.push_back('{1'b0, 1'b0, 8'h01, 8'h00, 5'd0,  1'b0, 1'b0, 160});
        tbl.push_back('{1'b1, 1'b0, 8'h48, 8'h00, 5'd1,  1'b0, 1'b0, 40});
        tbl.push_back('{1'b1, 1'b0, 8'h49, 8'h00, 5'd2,  1'b0, 1'b0, 40});
        tbl.push_back('{1'b0, 1'b1, 8'h00, 8'h02, 5'd2,  1'b0, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b0, 8'h80, 8'h00, 5'd0,  1'b0, 1'b0, 40});
        tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h48, 5'd1,  1'b0, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h49, 5'd2,  1'b0, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h20, 5'd3,  1'b0, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b0, 8'h9F, 8'h00, 5'd31, 1'b0, 1'b0, 40});
        tbl.push_back('{1'b1, 1'b0, 8'h41, 8'h00, 5'd0,  1'b0, 1'b0, 40});
        tbl.push_back('{1'b1, 1'b0, 8'h42, 8'h00, 5'd1,  1'b0, 1'b0, 40});
        tbl.push_back('{1'b0, 1'b0, 8'h9F, 8'h00, 5'd31, 1'b0, 1'b0, 40});
        tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h41, 5'd0,  1'b0, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h42, 5'd1,  1'b0, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b0, 8'h04, 8'h00, 5'd1,  1'b0, 1'b0, 40});
        tbl.push_back('{1'b0, 1'b0, 8'h80, 8'h00, 5'd0,  1'b0, 1'b0, 40});
        tbl.push_back('{1'b1, 1'b0, 8'h55, 8'h00, 5'd31, 1'b0, 1'b0, 40});
        tbl.push_back('{1'b0, 1'b1, 8'h00, 8'h1F, 5'd31, 1'b0, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b0, 8'h80, 8'h00, 5'd0,  1'b0, 1'b0, 40});
        tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h55, 5'd31, 1'b0, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b0, 8'h06, 8'h00, 5'd31, 1'b0, 1'b0, 40});
        tbl.push_back('{1'b0, 1'b0, 8'h0C, 8'h00, 5'd31, 1'b1, 1'b0, 40});
        tbl.push_back('{1'b0, 1'b0, 8'h08, 8'h00, 5'd31, 1'b0, 1'b0, 40});
        tbl.push_back('{1'b0, 1'b0, 8'h0C, 8'h00, 5'd31, 1'b1, 1'b0, 40});
        tbl.push_back('{1'b0, 1'b0, 8'hA0, 8'h00, 5'd0,  1'b1, 1'b1, 40});
        tbl.push_back('{1'b0, 1'b0, 8'h85, 8'h00, 5'd5,  1'b1, 1'b1, 40});
        tbl.push_back('{1'b0, 1'b0, 8'h02, 8'h00, 5'd0,  1'b1, 1'b1, 160});

        foreach (tbl[i]) begin
            txn(tbl[i].rs, tbl[i].rw, tbl[i].data, rd, den);
            busy_hi = 0;
            wait_idle();
            if (tbl[i].rw) begin
                check($sformatf("t%0d_rd", i), rd, tbl[i].rd);
                check($sformatf("t%0d_drive", i), den, 1);
            end
            check($sformatf("t%0d_ac", i), addrCounter, tbl[i].ac);
            check($sformatf("t%0d_disp", i), displayOn, tbl[i].disp);
            check($sformatf("t%0d_err", i), cmdError, tbl[i].err);
            check($sformatf("t%0d_busy_len", i), busy_hi, tbl[i].busy);
        end
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
        exp_mem[0] = 8'h55;
        exp_mem[1] = 8'h49;
        exp_mem[31] = 8'h41;
        for (int i = 0; i < 32; i++) begin
            dbgAddr = 5'(i);
            #1;
            check($sformatf("tbl_ddram%0d", i), dbgData, exp_mem[i]);
        end

        // Power-down mid-busy.
        txn(1'b0, 1'b0, 8'h87, rd, den);
        repeat (10) @(negedge clk);
        check("pd_pre_busy", busyFlag, 1);
        lcdOn = 1'b0;
        @(negedge clk);
        check("pd_busy", busyFlag, 0);
        check("pd_ac", addrCounter, 0);
        check("pd_drive", lcdBusDriveEn, 0);
        check("pd_disp", displayOn, 0);
        check("pd_err", cmdError, 0);
        lcdRsSelect = 1'b0;
        lcdReadWriteSel = 1'b1;
        lcdEnable = 1'b1;
        repeat (4) @(negedge clk);
        check("pd_ignore_en", lcdBusDriveEn, 0);
        lcdEnable = 1'b0;
        repeat (3) @(negedge clk);
        lcdOn = 1'b1;
        busy_hi = 0;
        wait_idle();
        check("pd_reinit_len", busy_hi, 160);

        // Write while busy is dropped; countdown not restarted.
        txn(1'b0, 1'b0, 8'h01, rd, den);
        wait_idle();
        txn(1'b0, 1'b0, 8'h0C, rd, den);
        busy_hi = 0;
        txn(1'b1, 1'b0, 8'h77, rd, den);
        txn(1'b0, 1'b1, 8'h00, rd, den);
        check("bw_status_bit7", rd[7], 1);
        wait_idle();
        check("bw_busy_len", busy_hi, 40);
        check("bw_err", cmdError, 1);
        check("bw_disp", displayOn, 1);
        check("bw_ac", addrCounter, 0);
        dbgAddr = 5'd0;
        #1;
        check("bw_ddram0", dbgData, 8'h20);

        // Reset in the middle of a data write.
        txn(1'b0, 1'b0, 8'h83, rd, den);
        wait_idle();
        lcdRsSelect = 1'b1;
        lcdReadWriteSel = 1'b0;
        lcdBusIn = 8'h99;
        lcdEnable = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        lcdEnable = 1'b0;
        repeat (3) @(negedge clk);
        check("rmt_ac", addrCounter, 0);
        check("rmt_err", cmdError, 0);
        reset = 1'b0;
        wait_idle();
        dbgAddr = 5'd3;
        #1;
        check("rmt_ddram3", dbgData, 8'h20);

        // Enable pulse too short to be sampled is lost.
        lcdRsSelect = 1'b1;
        lcdReadWriteSel = 1'b0;
        lcdBusIn = 8'h66;
        #1 lcdEnable = 1'b1;
        #2 lcdEnable = 1'b0;
        repeat (8) @(negedge clk);
        dbgAddr = 5'd0;
        #1;
        check("glitch_ddram0", dbgData, 8'h20);
        check("glitch_ac", addrCounter, 0);
        check("glitch_busy", busyFlag, 0);
        check("glitch_err", cmdError, 0);

        // Randomized traffic against the model.
        txn(1'b0, 1'b0, 8'h01, rd, den);
        wait_idle();
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        m_ac = 5'd0;
        m_id = 1'b1;
        m_disp = 1'b0;
        m_err = 1'b0;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            r = $urandom;
            rs = 1'b0;
            rw = 1'b0;
            d = 8'h00;
            case (k)
                0, 1: begin rs = 1'b1; d = r[7:0]; end
                2: begin rs = 1'b1; rw = 1'b1; end
                3: rw = 1'b1;
                4: d = {1'b1, r[6:0]};
                5: d = {6'b000001, r[1:0]};
                6: d = {5'b00001, r[2:0]};
                7: d = {3'b001, r[4:0]};
                8: d = {4'b0001, r[3:0]};
                default: d = 8'h02;
            endcase
            exp_rd = 8'h00;
            exp_busy = 0;
            if (rw) begin
                if (rs) begin
                    exp_rd = mdl[m_ac];
                    m_ac = m_id ? m_ac + 5'd1 : m_ac - 5'd1;
                end else begin
                    exp_rd = {3'b000, m_ac};
                end
            end else begin
                exp_busy = model_write(rs, d);
            end
            txn(rs, rw, d, rd, den);
            busy_hi = 0;
            wait_idle();
            if (rw) check($sformatf("r%0d_rd", i), rd, exp_rd);
            check($sformatf("r%0d_ac", i), addrCounter, m_ac);
            check($sformatf("r%0d_disp", i), displayOn, m_disp);
            check($sformatf("r%0d_err", i), cmdError, m_err);
            check($sformatf("r%0d_busy_len", i), busy_hi, exp_busy);
        end
        for (int i = 0; i < 32; i++) begin
            dbgAddr = 5'(i);
            #1;
            check($sformatf("rnd_ddram%0d", i), dbgData, mdl[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
